matmul_stream: RTL
==================

Name: matmul_stream

Overview:
- Parametrised successor to the fixed 32-bit `matmul` datapath.
- Accepts two NxN matrices A and B as a valid/ready element stream. Stores both in internal register arrays.
- Computes C = A×B with a single sequential multiply-accumulate unit. Emits C row-major on a valid/ready output stream with backpressure.
- Sits between the host-side loader and result sink, in place of the fixed matmul instance.

Parameters:
- N, 4, matrix dimension (2..16).
- DATA_W, 8, width of each A/B element.
- ACC_W, 2*DATA_W+$clog2(N), width of each C element; must be at least this default.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mode_signed  input  1  1 = two's-complement elements, 0 = unsigned; sampled on the first accepted load beat.
- in_valid  input  1  load beat valid.
- in_ready  output  1  block accepts a load beat.
- in_a  input  DATA_W  element A[r][c], row-major.
- in_b  input  DATA_W  element B[r][c], same index as in_a.
- in_last  input  1  marks beat N*N-1.
- out_valid  output  1  out_c valid.
- out_ready  input  1  sink accepts out_c.
- out_c  output  ACC_W  element C[i][j], row-major.
- out_last  output  1  marks C[N-1][N-1].
- busy  output  1  high in any state other than IDLE.
- err_len  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; in_ready=0, out_valid=0, out_c=0, out_last=0, busy=0, err_len=0; all counters=0. Array contents are don't-care.
- States: IDLE, LOAD, COMPUTE, OUTPUT.
- IDLE:
  - in_ready=1.
  - On the first in_valid&&in_ready beat: write index 0, latch mode_signed, go to LOAD. Load index is now 1.
  - N=1 special case: if that beat is the last beat, go directly to COMPUTE.
- LOAD:
  - in_ready=1. Each handshake writes A[idx] and B[idx] from in_a/in_b, then increments idx.
  - Handshake at idx=N*N-1: go to COMPUTE, independent of in_last.
  - If in_last is low on that final beat: pulse err_len.
  - If in_last is high at idx<N*N-1: pulse err_len, discard the frame, return to IDLE.
- COMPUTE:
  - in_ready=0. Counters i, j, k start at 0; the accumulator clears at k=0.
  - Each cycle: acc += A[i][k]*B[k][j], with operands extended per the latched mode. Then k++.
  - When k=N-1: load acc into out_c and go to OUTPUT. out_valid=1 on the following cycle.
  - So each element takes N compute cycles plus 1 register cycle.
- OUTPUT:
  - out_c, out_valid and out_last hold stable until out_valid&&out_ready. No change while stalled.
  - On handshake: advance j, then i.
    - If C[N-1][N-1] was just sent: go to IDLE. out_valid drops in the same cycle as the state change.
    - Otherwise: return to COMPUTE.
  - out_last=1 only with C[N-1][N-1].
- No overlap: a new frame is not accepted until the last C element is handshaken.
- Latency: first out_valid is N+1 cycles after the final load handshake. With out_ready held high, total frame latency is N*N*(N+2) cycles.
- Arithmetic: products are 2*DATA_W; sums are ACC_W. Sign- or zero-extension follows mode. No saturation; ACC_W is sized so overflow cannot occur.
- out_ready held low indefinitely: the block stalls with state preserved.
- in_valid asserted in COMPUTE/OUTPUT: ignored, because in_ready=0.
- rst asserted mid-frame: immediate abort to reset values; no partial output.

Decomposition:
- Package matmul_pkg holds:
  - state enum {IDLE, LOAD, COMPUTE, OUTPUT};
  - function acc_width(N, DATA_W);
  - localparams for N limits.
- Sub-module mac_unit (parameters DATA_W, ACC_W):
  - inputs: clk, rst, clr, en, signed_mode, a, b;
  - output: acc;
  - registered acc += a*b; clr forces acc=0 before accumulating.

Test Plan:
- N=2, unsigned, A=[[1,2],[3,4]], B=identity, out_ready=1 -> out_c=1,2,3,4; out_last on 4th; first out_valid 3 cycles after the last load beat.
- N=4, DATA_W=8, signed, A all -128, B all -128 -> every C element 65536; no overflow at ACC_W=18.
- N=2, unsigned, A=B=[[255,255],[255,255]] -> every C element 130050; then signed with same bit patterns (-1) -> every element 2.
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], out_ready toggling 0/1 every 3 cycles -> sequence 19,22,43,50; out_c stable while stalled.
- N=4, in_last at beat 5 -> err_len pulse, return to IDLE, no out_valid. N=4, in_last missing on beat 15 -> err_len pulse, correct results still emitted.
- rst pulsed low during OUTPUT of C[0][1] -> all outputs 0 immediately. The next full frame computes correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and helpers for the streaming matrix multiplier.
//   state_e    - controller states
//   acc_width  - minimum C element width for an NxN product of DATA_W-bit elements
//   N_MIN/MAX  - supported range of the matrix dimension
package matmul_pkg;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StOutput
    } state_e;

    // Each product needs 2*data_w bits; summing n of them adds clog2(n) bits.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned data_w);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: registered multiply-accumulate, acc <= (clr ? 0 : acc) + a*b when en.
//   clk, rst     - clock, asynchronous active-low reset
//   clr, en      - restart accumulation / accumulate this cycle
//   signed_mode  - 1: a and b are two's complement, 0: unsigned
//   a, b         - DATA_W operands
//   acc          - ACC_W running sum
module mac_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    // Extend to the full accumulator width up front; a modulo-2^ACC_W product then
    // gives the correct two's-complement result in both modes since the sum fits.
    assign a_ext = {{(ACC_W-DATA_W){signed_mode & a[DATA_W-1]}}, a};
    assign b_ext = {{(ACC_W-DATA_W){signed_mode & b[DATA_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) + prod;
        end
    end

endmodule

// File: rtl/matmul_stream.sv
// matmul_stream: loads NxN matrices A and B as a valid/ready element stream, computes
// C = A x B with one sequential MAC and streams C row-major with backpressure.
//   clk, rst                       - clock, asynchronous active-low reset
//   mode_signed                    - element signedness, sampled on the first load beat
//   in_valid/in_ready/in_a/in_b/in_last - load stream, A[r][c] and B[r][c] per beat
//   out_valid/out_ready/out_c/out_last  - result stream, out_last on C[N-1][N-1]
//   busy                           - not idle
//   err_len                        - one-cycle pulse on a framing error
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = acc_width(N, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_signed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_c,
    output logic              out_last,
    output logic              busy,
    output logic              err_len
);

    localparam int unsigned IdxW = $clog2(N * N);
    localparam int unsigned CntW = $clog2(N);
    localparam int unsigned KW   = $clog2(N + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N * N - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(N - 1);
    localparam logic [KW-1:0]   KDone   = KW'(N);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("matmul_stream: N out of supported range");
    end

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [CntW-1:0]   i_q;
    logic [CntW-1:0]   j_q;
    logic [KW-1:0]     k_q;
    logic              signed_q;

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];

    logic              load_hs;
    logic [CntW-1:0]   k_rd;
    logic [IdxW-1:0]   a_addr;
    logic [IdxW-1:0]   b_addr;
    logic              mac_en;
    logic              mac_clr;
    logic [ACC_W-1:0]  acc;

    // in_ready is only ever high in IDLE/LOAD.
    assign load_hs = in_valid && in_ready;
    assign busy    = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (load_hs) begin
            a_mem[idx_q] <= in_a;
            b_mem[idx_q] <= in_b;
        end
    end

    // k reaches N on the cycle that registers the result; keep the read address in range.
    assign k_rd    = (k_q < KDone) ? k_q[CntW-1:0] : '0;
    assign a_addr  = IdxW'(i_q) * IdxW'(N) + IdxW'(k_rd);
    assign b_addr  = IdxW'(k_rd) * IdxW'(N) + IdxW'(j_q);
    assign mac_en  = (state_q == StCompute) && (k_q != KDone);
    assign mac_clr = (k_q == '0);

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .clr         (mac_clr),
        .en          (mac_en),
        .signed_mode (signed_q),
        .a           (a_mem[a_addr]),
        .b           (b_mem[b_addr]),
        .acc         (acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            signed_q  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_last  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            unique case (state_q)
                StIdle, StLoad: begin
                    if (load_hs) begin
                        if (state_q == StIdle) begin
                            signed_q <= mode_signed;
                        end
                        if (idx_q == LastIdx) begin
                            // Frame length is authoritative; a missing in_last is only flagged.
                            state_q  <= StCompute;
                            in_ready <= 1'b0;
                            idx_q    <= '0;
                            i_q      <= '0;
                            j_q      <= '0;
                            k_q      <= '0;
                            err_len  <= !in_last;
                        end else if (in_last) begin
                            state_q <= StIdle;
                            idx_q   <= '0;
                            err_len <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                StCompute: begin
                    if (k_q == KDone) begin
                        out_c     <= acc;
                        out_valid <= 1'b1;
                        out_last  <= (i_q == CntMax) && (j_q == CntMax);
                        state_q   <= StOutput;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        k_q       <= '0;
                        if (j_q == CntMax) begin
                            j_q <= '0;
                            if (i_q == CntMax) begin
                                i_q      <= '0;
                                state_q  <= StIdle;
                                in_ready <= 1'b1;
                            end else begin
                                i_q     <= i_q + 1'b1;
                                state_q <= StCompute;
                            end
                        end else begin
                            j_q     <= j_q + 1'b1;
                            state_q <= StCompute;
                        end
                    end
                end
            endcase
        end
    end

endmodule
